// File: rtl/ivs_frame_gen_if.sv
// Pixel-address request channel between the IVS frame generator and the fetch/DMA stage.
// One beat moves on every cycle where req_valid and req_ready are both high.
interface ivs_frame_gen_if #(
  parameter int AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_eol;
  logic          req_eof;

  modport master (
    output req_valid,
    output req_addr,
    output req_eol,
    output req_eof,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_eol,
    input  req_eof,
    output req_ready
  );
endinterface

// File: rtl/ivs_frame_gen.sv
// IVS raster frame generator: walks a width x height pixel window line by line and emits
// one byte address per accepted beat, with busy/done-irq/config-error status and a frame counter.
module ivs_frame_gen #(
  parameter int AW        = 32,
  parameter int DIM_W     = 16,
  parameter int BPP_BYTES = 4
) (
  input  logic             hclk,
  input  logic             hrst_n,
  input  logic             sw_rst,
  input  logic [31:0]      glb_ctrl,
  input  logic [AW-1:0]    cfg_par0,
  input  logic [31:0]      cfg_par1,
  input  logic [AW-1:0]    cfg_par2,
  ivs_frame_gen_if.master  req,
  output logic             busy,
  output logic             done_irq,
  output logic             cfg_err,
  output logic [15:0]      frm_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Every flop of the block lives in one record so both reset sources clear it identically.
  typedef struct packed {
    state_t           state;
    logic             start_prev;
    logic [AW-1:0]    base;
    logic [AW-1:0]    stride;
    logic [AW-1:0]    line_base;
    logic [AW-1:0]    addr;
    logic [DIM_W-1:0] wid;
    logic [DIM_W-1:0] hgt;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             valid;
    logic             eol;
    logic             eof;
    logic             busy;
    logic             done_irq;
    logic             cfg_err;
    logic [15:0]      frm_cnt;
  } regs_t;

  regs_t r;

  logic             start_edge;
  logic             handshake;
  logic [DIM_W-1:0] x_nxt;
  logic [DIM_W-1:0] y_nxt;
  logic [AW-1:0]    line_base_nxt;
  logic [AW-1:0]    addr_nxt;
  logic             eol_nxt;
  logic             eof_nxt;
  logic             unused_ctrl_bits;

  assign start_edge       = glb_ctrl[0] & ~r.start_prev;
  assign handshake        = r.valid & req.req_ready;
  assign unused_ctrl_bits = ^glb_ctrl[31:4];

  // Position and beat flags for the pixel after the one currently presented.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    x_nxt         = r.x + DIM_W'(1);
    y_nxt         = r.y;
    line_base_nxt = r.line_base;
    addr_nxt      = r.addr + AW'(BPP_BYTES);
    if (r.eol) begin
      x_nxt         = '0;
      y_nxt         = r.y + DIM_W'(1);
      line_base_nxt = r.line_base + r.stride;
      addr_nxt      = line_base_nxt;
    end
    eol_nxt = (x_nxt == r.wid - DIM_W'(1));
    eof_nxt = eol_nxt && (y_nxt == r.hgt - DIM_W'(1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r <= '0;
    end else if (sw_rst) begin
      r <= '0;
    end else begin
      r.start_prev <= glb_ctrl[0];
      if (glb_ctrl[3]) r.done_irq <= 1'b0;

      case (r.state)
        IDLE: begin
          if (start_edge) begin
            r.done_irq <= 1'b0;
            r.cfg_err  <= 1'b0;
            if ((cfg_par1[DIM_W-1:0] == '0) || (cfg_par1[2*DIM_W-1:DIM_W] == '0)) begin
              r.cfg_err <= 1'b1;
            end else begin
              r.base   <= cfg_par0;
              r.stride <= cfg_par2;
              r.wid    <= cfg_par1[DIM_W-1:0];
              r.hgt    <= cfg_par1[2*DIM_W-1:DIM_W];
              r.busy   <= 1'b1;
              r.state  <= LOAD;
            end
          end
        end

        LOAD: begin
          r.x         <= '0;
          r.y         <= '0;
          r.line_base <= r.base;
          r.addr      <= r.base;
          r.valid     <= 1'b1;
          r.eol       <= (r.wid == DIM_W'(1));
          r.eof       <= (r.wid == DIM_W'(1)) && (r.hgt == DIM_W'(1));
          r.state     <= RUN;
        end

        RUN: begin
          if (handshake) begin
            if (glb_ctrl[2]) begin
              r.valid <= 1'b0;
              r.eol   <= 1'b0;
              r.eof   <= 1'b0;
              r.busy  <= 1'b0;
              r.state <= IDLE;
            end else if (r.eof) begin
              r.valid <= 1'b0;
              r.eol   <= 1'b0;
              r.eof   <= 1'b0;
              r.state <= DONE;
            end else begin
              r.x         <= x_nxt;
              r.y         <= y_nxt;
              r.line_base <= line_base_nxt;
              r.addr      <= addr_nxt;
              r.eol       <= eol_nxt;
              r.eof       <= eof_nxt;
            end
          end
        end

        DONE: begin
          r.frm_cnt <= r.frm_cnt + 16'd1;
          if (glb_ctrl[1]) r.done_irq <= 1'b1;
          r.busy  <= 1'b0;
          r.state <= IDLE;
        end

        default: r.state <= IDLE;
      endcase
    end
  end

  assign req.req_valid = r.valid;
  assign req.req_addr  = r.addr;
  assign req.req_eol   = r.eol;
  assign req.req_eof   = r.eof;
  assign busy          = r.busy;
  assign done_irq      = r.done_irq;
  assign cfg_err       = r.cfg_err;
  assign frm_cnt       = r.frm_cnt;

endmodule

// File: tb/tb_ivs_frame_gen.sv
// Self-checking bench for ivs_frame_gen: directed scenarios plus random frames/ready patterns,
// every beat compared against an address list computed from base + y*stride + x*BPP.
module tb_ivs_frame_gen;

  localparam int AW  = 32;
  localparam int BPP = 4;

  logic        hclk     = 1'b0;
  logic        hrst_n   = 1'b0;
  logic        sw_rst   = 1'b0;
  logic [31:0] glb_ctrl = '0;
  logic [31:0] cfg_par0 = '0;
  logic [31:0] cfg_par1 = '0;
  logic [31:0] cfg_par2 = '0;
  logic        busy;
  logic        done_irq;
  logic        cfg_err;
  logic [15:0] frm_cnt;

  int vectors = 0;
  int errors  = 0;
  int frames  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        eol;
    logic        eof;
  } beat_t;

  beat_t exp_q[$];

  ivs_frame_gen_if #(.AW(AW)) req_if ();

  ivs_frame_gen #(.AW(AW), .DIM_W(16), .BPP_BYTES(BPP)) dut (
    .hclk     (hclk),
    .hrst_n   (hrst_n),
    .sw_rst   (sw_rst),
    .glb_ctrl (glb_ctrl),
    .cfg_par0 (cfg_par0),
    .cfg_par1 (cfg_par1),
    .cfg_par2 (cfg_par2),
    .req      (req_if.master),
    .busy     (busy),
    .done_irq (done_irq),
    .cfg_err  (cfg_err),
    .frm_cnt  (frm_cnt)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and registered outputs sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic build_model(input logic [31:0] base, input int w, input int h,
                             input logic [31:0] stride);
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        beat_t b;
        b.addr = base + 32'(y) * stride + 32'(x) * 32'(BPP);
        b.eol  = (x == w - 1);
        b.eof  = (x == w - 1) && (y == h - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic check_beat(input string ctx, input int idx);
    if (idx < exp_q.size()) begin
      check({ctx, "_addr"}, req_if.req_addr, exp_q[idx].addr);
      check({ctx, "_eol"},  req_if.req_eol,  exp_q[idx].eol);
      check({ctx, "_eof"},  req_if.req_eof,  exp_q[idx].eof);
    end else begin
      check({ctx, "_extra_beat"}, 1, 0);
    end
  endtask

  // Runs one whole frame with ready asserted ready_pct percent of the time.
  task automatic run_frame(input string ctx, input logic [31:0] base, input int w, input int h,
                           input logic [31:0] stride, input int ready_pct);
    int idx;
    int first;
    int busy_cyc;
    bit ended;
    build_model(base, w, h, stride);
    cfg_par0 = base;
    cfg_par1 = {16'(h), 16'(w)};
    cfg_par2 = stride;
    idx = 0; first = -1; busy_cyc = 0; ended = 1'b0;
    tick();
    glb_ctrl[0] = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !ended; cyc++) begin
      tick();
      glb_ctrl[0] = 1'b0;
      req_if.req_ready = ($urandom_range(99) < 32'(ready_pct));
      if (busy) busy_cyc++;
      if (req_if.req_valid) begin
        if (first < 0) first = cyc;
        check_beat(ctx, idx);
        if (req_if.req_ready) idx++;
      end
      if (!busy && cyc > 1) ended = 1'b1;
    end
    req_if.req_ready = 1'b0;
    frames++;
    check({ctx, "_frame_end"}, ended, 1);
    check({ctx, "_beats"}, idx, exp_q.size());
    check({ctx, "_first_valid"}, first, 2);
    if (ready_pct == 100) check({ctx, "_busy_cycles"}, busy_cyc, exp_q.size() + 2);
    check({ctx, "_frm_cnt"}, frm_cnt, 16'(frames));
    check({ctx, "_done_irq"}, done_irq, glb_ctrl[1]);
  endtask

  initial begin
    int beats;
    req_if.req_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", req_if.req_valid, 0);
    check("rst_busy", busy, 0);
    hrst_n = 1'b1;
    tick();
    check("rst_addr", req_if.req_addr, 0);
    check("rst_done_irq", done_irq, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_frm_cnt", frm_cnt, 0);

    // Reference frame, full throughput, irq enabled
    glb_ctrl = 32'h2;
    run_frame("ref", 32'h1000, 4, 2, 32'h100, 100);

    // Level irq clear
    glb_ctrl[3] = 1'b1;
    tick();
    glb_ctrl[3] = 1'b0;
    check("irq_clr", done_irq, 0);

    // Same frame with random backpressure
    run_frame("stall", 32'h1000, 4, 2, 32'h100, 50);

    // Zero width: error flag, no activity, done_irq cleared by the start edge
    cfg_par0 = 32'h3000;
    cfg_par1 = {16'd5, 16'd0};
    tick();
    glb_ctrl[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      glb_ctrl[0] = 1'b0;
      check("zero_busy", busy, 0);
      check("zero_valid", req_if.req_valid, 0);
    end
    check("zero_cfg_err", cfg_err, 1);
    check("zero_done_irq", done_irq, 0);

    // Address wrap; a valid start clears cfg_err
    run_frame("wrap", 32'hFFFF_FFF8, 4, 1, 32'h0, 60);
    check("wrap_cfg_err", cfg_err, 0);

    // Degenerate shapes and random frames
    glb_ctrl = 32'h0;
    run_frame("w1", 32'h0000_8000, 1, 3, 32'h40, 100);
    run_frame("h1", 32'h0000_9000, 3, 1, 32'h40, 70);
    for (int i = 0; i < 4; i++) begin
      run_frame("rand", $urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 5)),
                int'($urandom_range(1, 4)), $urandom, int'($urandom_range(30, 100)));
    end

    // Abort held: frame ends right after the first handshake
    cfg_par0 = 32'h2000;
    cfg_par1 = {16'd8, 16'd8};
    cfg_par2 = 32'h400;
    glb_ctrl = 32'h4;
    req_if.req_ready = 1'b1;
    tick();
    glb_ctrl[0] = 1'b1;
    tick();
    glb_ctrl[0] = 1'b0;
    check("abort_load_busy", busy, 1);
    check("abort_load_valid", req_if.req_valid, 0);
    tick();
    check("abort_first_valid", req_if.req_valid, 1);
    check("abort_first_addr", req_if.req_addr, 32'h2000);
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", req_if.req_valid, 0);
    check("abort_frm_cnt", frm_cnt, 16'(frames));
    glb_ctrl = 32'h0;

    // Soft reset mid-frame while stalled
    req_if.req_ready = 1'b0;
    tick();
    glb_ctrl[0] = 1'b1;
    tick();
    glb_ctrl[0] = 1'b0;
    tick();
    check("srst_pre_valid", req_if.req_valid, 1);
    tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    frames = 0;
    check("srst_valid", req_if.req_valid, 0);
    check("srst_addr", req_if.req_addr, 0);
    check("srst_eol", req_if.req_eol, 0);
    check("srst_eof", req_if.req_eof, 0);
    check("srst_busy", busy, 0);
    check("srst_frm_cnt", frm_cnt, 0);
    check("srst_done_irq", done_irq, 0);
    check("srst_cfg_err", cfg_err, 0);

    // Start held high for 100 cycles, config rewritten mid-frame
    build_model(32'h4000, 2, 1, 32'h80);
    cfg_par0 = 32'h4000;
    cfg_par1 = {16'd1, 16'd2};
    cfg_par2 = 32'h80;
    req_if.req_ready = 1'b1;
    beats = 0;
    tick();
    glb_ctrl[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 2) cfg_par1 = {16'd7, 16'd7};
      if (req_if.req_valid) begin
        check_beat("held", beats);
        beats++;
      end
    end
    glb_ctrl[0] = 1'b0;
    frames++;
    check("held_beats", beats, 2);
    check("held_frm_cnt", frm_cnt, 16'(frames));
    check("held_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
